fetch_redirect_unit: RTL

- PC register plus IF/ID pipeline register, sitting directly downstream of the branch control unit.
- Consumes BRANCH_SELECT and TARGET_ADDRESS, which are resolved in EX, and redirects instruction fetch.
- Bubbles the wrong-path IF/ID contents and issues a flush to ID/EX.
- Handles hazard-unit stalls and a busy instruction memory, including a redirect that arrives while the memory is busy.

---
 rtl/fetch_redirect_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: PC register and IF/ID pipeline register.
// Taken branches and jumps resolved in EX redirect the PC, and the
// wrong-path IF/ID contents are replaced by a bubble. When the instruction
// memory is busy, a redirect is parked in PENDING until the memory is free.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BRANCH_SELECT,
  input  logic [31:0]          TARGET_ADDRESS,
  input  logic                 STALL,
  input  logic                 IMEM_BUSY,
  input  logic [31:0]          INSTRUCTION,
  output logic [31:0]          PC,
  output logic [31:0]          IFID_PC,
  output logic [31:0]          IFID_PC_PLUS_4,
  output logic [31:0]          IFID_INSTRUCTION,
  output logic                 IFID_VALID,
  output logic                 FLUSH,
  output logic                 MISALIGNED,
  output logic [CNT_WIDTH-1:0] REDIRECT_COUNT
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Empty IF/ID slot: carries a NOP and is marked invalid.
  function automatic ifid_t bubble();
    ifid_t b;
    b.pc        = 32'h0000_0000;
    b.pc_plus_4 = 32'h0000_0004;
    b.instr     = NOP_INSTR;
    b.valid     = 1'b0;
    return b;
  endfunction

  state_t               state_r,         state_s;
  logic [31:0]          pc_r,            pc_s;
  logic [31:0]          pend_target_r,   pend_target_s;
  ifid_t                ifid_r,          ifid_s;
  logic                 misaligned_r,    misaligned_s;
  logic [CNT_WIDTH-1:0] redirect_count_r, redirect_count_s;
  logic [31:0]          aligned_target_s;

  assign aligned_target_s = {TARGET_ADDRESS[31:2], 2'b00};

  // Next-state and next-register computation; redirect > stall > busy > fetch.
  always_comb begin
    state_s          = state_r;
    pc_s             = pc_r;
    pend_target_s    = pend_target_r;
    ifid_s           = ifid_r;
    misaligned_s     = 1'b0;
    redirect_count_s = redirect_count_r;
    case (state_r)
      ST_RUN: begin
        if (BRANCH_SELECT) begin
          ifid_s       = bubble();
          misaligned_s = |TARGET_ADDRESS[1:0];
          if (IMEM_BUSY) begin
            // Memory cannot take the new address yet: park the target.
            pend_target_s = aligned_target_s;
            state_s       = ST_PENDING;
          end else begin
            pc_s             = aligned_target_s;
            redirect_count_s = redirect_count_r + CNT_ONE;
          end
        end else if (STALL) begin
          ifid_s = ifid_r;
        end else if (IMEM_BUSY) begin
          ifid_s = bubble();
        end else begin
          ifid_s.pc        = pc_r;
          ifid_s.pc_plus_4 = pc_r + 32'd4;
          ifid_s.instr     = INSTRUCTION;
          ifid_s.valid     = 1'b1;
          pc_s             = pc_r + 32'd4;
        end
      end
      ST_PENDING: begin
        // Stalls and further redirects are ignored until the target lands.
        ifid_s = bubble();
        if (IMEM_BUSY) begin
          state_s = ST_PENDING;
        end else begin
          pc_s             = pend_target_r;
          redirect_count_s = redirect_count_r + CNT_ONE;
          state_s          = ST_RUN;
        end
      end
      default: begin
        state_s = ST_RUN;
        ifid_s  = bubble();
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r          <= ST_RUN;
      pc_r             <= RESET_VECTOR;
      pend_target_r    <= 32'h0000_0000;
      ifid_r           <= bubble();
      misaligned_r     <= 1'b0;
      redirect_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r          <= state_s;
      pc_r             <= pc_s;
      pend_target_r    <= pend_target_s;
      ifid_r           <= ifid_s;
      misaligned_r     <= misaligned_s;
      redirect_count_r <= redirect_count_s;
    end
  end

  assign PC               = pc_r;
  assign IFID_PC          = ifid_r.pc;
  assign IFID_PC_PLUS_4   = ifid_r.pc_plus_4;
  assign IFID_INSTRUCTION = ifid_r.instr;
  assign IFID_VALID       = ifid_r.valid;
  assign MISALIGNED       = misaligned_r;
  assign REDIRECT_COUNT   = redirect_count_r;
  // The flush has to reach ID/EX in the same cycle the branch resolves.
  assign FLUSH            = BRANCH_SELECT & ~RESET;

endmodule
